phase_acc_mc: RTL
=================

PHASE_ACC_MC -- requirements
Module: phase_acc_mc

Interface
REQ-001 The block SHALL have parameter ACC_WIDTH, default 32: width of accumulator and phase increment.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16: output phase width, 1 <= OUT_WIDTH <= ACC_WIDTH.
REQ-003 The block SHALL have parameter NUM_CHAN, default 4: independent channels, 1..16.
REQ-004 The block SHALL have parameter CHAN_W, default 2: channel index width, 2^CHAN_W >= NUM_CHAN.
REQ-005 The block SHALL have the following ports.
- clk  in  1  sole clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous, active-high soft clear.
- i_tdata  in  ACC_WIDTH  phase increment; used only on tlast beats.
- i_tuser  in  CHAN_W  channel index.
- i_tlast, i_tvalid  in  1 each  AXI-Stream input.
- i_tready  out  1  AXI-Stream input ready.
- o_tdata  out  OUT_WIDTH  phase sample.
- o_tuser  out  CHAN_W  channel index, copied from input.
- o_tlast, o_tvalid  out  1 each  AXI-Stream output.
- o_tready  in  1  AXI-Stream output ready.

Function
REQ-006 Per channel c, the block SHALL hold registers acc[c] and inc[c], both ACC_WIDTH.
REQ-007 An input handshake SHALL occur when i_tvalid & i_tready.
REQ-008 On a handshake with i_tlast=1, in-range channel c: inc[c] <= i_tdata, acc[c] <= 0, emitted o_tdata = 0.
REQ-009 On a handshake with i_tlast=0, in-range channel c: emitted o_tdata = acc[c][ACC_WIDTH-1 -: OUT_WIDTH]; acc[c] <= acc[c] + inc[c] modulo 2^ACC_WIDTH.
REQ-010 Output truncation SHALL keep the top OUT_WIDTH bits; no rounding.
REQ-011 Wrap-around SHALL be silent modular arithmetic.
REQ-012 Channel index >= NUM_CHAN SHALL consume the beat, emit o_tdata = 0 with tuser/tlast copied, and update no state.
REQ-013 Channels SHALL be fully independent; a beat on channel c SHALL NOT alter any other channel's state.
REQ-014 Output SHALL be registered, 1-cycle latency: beat accepted at edge N appears on o_* after edge N.
REQ-015 i_tready SHALL equal (~o_tvalid | o_tready) & ~clear, allowing full throughput of one beat per cycle.
REQ-016 While o_tvalid=1 and o_tready=0, o_tdata/o_tuser/o_tlast SHALL hold stable.
REQ-017 Back-to-back beats on the same channel SHALL each see the updated accumulator; no stale read.
REQ-018 On clear: all acc, inc <= 0 and o_tvalid <= 0; a pending output beat is dropped; no input beat is accepted that cycle.

Reset
REQ-019 On reset, all acc[c] and inc[c] SHALL be 0, and o_tvalid, o_tlast, o_tdata and o_tuser SHALL be 0.
REQ-020 Reset SHALL take precedence over clear and over any handshake, including mid-packet.
REQ-021 The first cycle after reset deasserts SHALL show i_tready = 1.

Configuration
REQ-022 Macro PHASE_ACC_MC_WRAP_FLAG_EN defined: an extra output o_twrap (1 bit, registered with o_tdata) SHALL be 1 when that beat's accumulate step overflowed 2^ACC_WIDTH; it SHALL be 0 on tlast and out-of-range beats and 0 after reset.
REQ-023 Macro undefined: o_twrap port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Package phase_acc_mc_pkg SHALL hold the default widths, the channel-index type and the max NUM_CHAN constant.
REQ-025 The output register and handshake SHALL be the sub-module phase_acc_out_reg, parametrised by payload width.
REQ-026 Per-channel state SHALL be a register array indexed by i_tuser, not RAM, so the block has no read latency.

Verification
REQ-027 Increment load: ACC_WIDTH=32, OUT_WIDTH=16, ch0 tlast i_tdata=0x0001_0000, then 4 non-last beats -> o_tdata 0,0,1,2,3.
REQ-028 Wrap: ch1 inc=0x8000_0000, 3 non-last beats -> o_tdata 0x0000,0x8000,0x0000; with PHASE_ACC_MC_WRAP_FLAG_EN, o_twrap=0,1,0.
REQ-029 Interleave: ch0 inc=0x0001_0000, ch2 inc=0x0002_0000, alternate ch0/ch2 beats -> ch0 outputs 0,1,2 and ch2 outputs 0,2,4 independently.
REQ-030 Backpressure: hold o_tready=0 for 5 cycles mid-stream -> o_* stable, i_tready=0, no beat lost or duplicated; full rate resumes after release.
REQ-031 Clear mid-stream: assert clear with a pending output -> o_tvalid=0 next cycle; subsequent non-last beats output 0 because inc=0.
REQ-032 Out-of-range: NUM_CHAN=3, beat with i_tuser=3 -> o_tdata=0, no accumulator in channels 0..2 changes.

Source files
------------

// File: rtl/phase_acc_mc_pkg.sv
// Shared widths, channel-index type and limits for the multi-channel
// phase accumulator.
package phase_acc_mc_pkg;

    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_NUM_CHAN  = 4;
    localparam int DEF_CHAN_W    = 2;
    localparam int MAX_NUM_CHAN  = 16;

    typedef logic [DEF_CHAN_W-1:0] chan_t;

    // Width of the payload carried by the output register.
    function automatic int out_payload_w(int out_w, int chan_w, int flag_w);
        return out_w + chan_w + 1 + flag_w;
    endfunction

endpackage

// File: rtl/phase_acc_mc_if.sv
// AXI-Stream in/out bundle for phase_acc_mc.
// slave = accumulator side, master = upstream source plus downstream sink.
// o_twrap exists only with PHASE_ACC_MC_WRAP_FLAG_EN.
interface phase_acc_mc_if
    import phase_acc_mc_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CHAN_W    = DEF_CHAN_W
) ();

    logic [ACC_WIDTH-1:0] i_tdata;
    logic [CHAN_W-1:0]    i_tuser;
    logic                 i_tlast;
    logic                 i_tvalid;
    logic                 i_tready;

    logic [OUT_WIDTH-1:0] o_tdata;
    logic [CHAN_W-1:0]    o_tuser;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready;
`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
    logic                 o_twrap;

    modport slave (
        input  i_tdata, i_tuser, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tuser, o_tlast, o_tvalid, o_twrap,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tuser, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tuser, o_tlast, o_tvalid, o_twrap,
        output o_tready
    );
`else
    modport slave (
        input  i_tdata, i_tuser, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tuser, o_tlast, o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tuser, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tuser, o_tlast, o_tvalid,
        output o_tready
    );
`endif

endinterface

// File: rtl/phase_acc_out_reg.sv
// One-deep registered output stage with valid/ready handshake.
// Ports: clk, reset, clear, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module phase_acc_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Accept when the slot is empty or draining this cycle; clear blocks input.
    assign in_ready = (~out_valid | out_ready) & ~clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/phase_acc_mc.sv
// Multi-channel phase accumulator: per-channel acc/inc registers, tlast loads
// the increment, other beats emit the truncated phase then accumulate.
// Ports: clk, reset, clear, s (phase_acc_mc_if.slave stream bundle).
// Optional PHASE_ACC_MC_WRAP_FLAG_EN adds o_twrap (accumulate overflow).
module phase_acc_mc
    import phase_acc_mc_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int NUM_CHAN  = DEF_NUM_CHAN,
    parameter int CHAN_W    = DEF_CHAN_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    phase_acc_mc_if.slave  s
);

`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
    localparam int WF = 1;
`else
    localparam int WF = 0;
`endif
    localparam int PW = out_payload_w(OUT_WIDTH, CHAN_W, WF);
    localparam logic [CHAN_W:0] NCH = (CHAN_W+1)'(NUM_CHAN);

    logic [ACC_WIDTH-1:0] acc [NUM_CHAN];
    logic [ACC_WIDTH-1:0] inc [NUM_CHAN];

    logic                 in_range;
    logic [CHAN_W-1:0]    idx;
    logic                 hs;
    logic [ACC_WIDTH-1:0] cur_acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [OUT_WIDTH-1:0] phase;
    logic [PW-1:0]        pay_in;
    logic [PW-1:0]        pay_out;

    assign in_range = ({1'b0, s.i_tuser} < NCH);
    // Out-of-range beats read a harmless channel; their result is discarded.
    assign idx      = in_range ? s.i_tuser : '0;
    assign hs       = s.i_tvalid & s.i_tready;
    assign cur_acc  = acc[idx];

`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
    logic [ACC_WIDTH:0] sum_ext;
    logic               wrap;

    assign sum_ext  = {1'b0, cur_acc} + {1'b0, inc[idx]};
    assign acc_next = sum_ext[ACC_WIDTH-1:0];
`else
    assign acc_next = cur_acc + inc[idx];
`endif

    always_comb begin
        phase = '0;
`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
        wrap  = 1'b0;
`endif
        if (in_range && !s.i_tlast) begin
            phase = cur_acc[ACC_WIDTH-1 -: OUT_WIDTH];
`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
            wrap  = sum_ext[ACC_WIDTH];
`endif
        end
    end

`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
    assign pay_in = {wrap, s.i_tlast, s.i_tuser, phase};
`else
    assign pay_in = {s.i_tlast, s.i_tuser, phase};
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                acc[c] <= '0;
                inc[c] <= '0;
            end
        end else if (hs && in_range) begin
            if (s.i_tlast) begin
                inc[idx] <= s.i_tdata;
                acc[idx] <= '0;
            end else begin
                acc[idx] <= acc_next;
            end
        end
    end

    phase_acc_out_reg #(
        .W (PW)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (s.i_tvalid),
        .in_ready  (s.i_tready),
        .in_data   (pay_in),
        .out_valid (s.o_tvalid),
        .out_ready (s.o_tready),
        .out_data  (pay_out)
    );

    assign s.o_tdata = pay_out[OUT_WIDTH-1:0];
    assign s.o_tuser = pay_out[OUT_WIDTH +: CHAN_W];
    assign s.o_tlast = pay_out[OUT_WIDTH+CHAN_W];
`ifdef PHASE_ACC_MC_WRAP_FLAG_EN
    assign s.o_twrap = pay_out[PW-1];
`endif

endmodule
